// File: rtl/matrix_row_ram.sv
`default_nettype none
// ============================================================================
// Module   : matrix_row_ram
// Brief    : Two-requester single-port row memory with zeroing init sweep,
//            request/grant arbitration and per-port read-valid tagging.
//            MATRIX_ROW_RAM_RR_ARB_EN selects round-robin (else fixed p0 prio).
// Revision : 1.0 - initial release
// ============================================================================
module matrix_row_ram #(
  parameter int DATA_W = 1024,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  output logic              ready,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              addr_err
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] c_last_row = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   c_depth    = (ADDR_W + 1)'(DEPTH);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_init_cnt;
  logic                w_init_adv;
  logic                w_p0_gnt;
  logic                w_p1_gnt;
  logic                w_p1_wins;
  logic                w_gnt;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_in_range;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;
  logic [DATA_W-1:0]   w_rd_data;

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                r_p0_rvalid;
  logic                r_p1_rvalid;
  logic [DATA_W-1:0]   r_p0_rdata;
  logic [DATA_W-1:0]   r_p1_rdata;
  logic                r_addr_err;

`ifdef MATRIX_ROW_RAM_RR_ARB_EN
  // r_ptr names the port that wins the next tie; flips only on a grant.
  logic r_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= 1'b0;
    end else if (w_p0_gnt) begin
      r_ptr <= 1'b1;
    end else if (w_p1_gnt) begin
      r_ptr <= 1'b0;
    end
  end

  assign w_p1_wins = r_ptr;
`else
  assign w_p1_wins = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_init_adv) begin
        r_init_cnt <= r_init_cnt + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init_adv  = 1'b0;
    w_p0_gnt    = 1'b0;
    w_p1_gnt    = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (ena) begin
          w_init_adv = 1'b1;
          if (r_init_cnt == c_last_row) begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (ena) begin
          if (p0_req && (!p1_req || !w_p1_wins)) begin
            w_p0_gnt = 1'b1;
          end else if (p1_req) begin
            w_p1_gnt = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Only one port can be granted, so its request fields drive the array.
  assign w_gnt       = w_p0_gnt | w_p1_gnt;
  assign w_sel_we    = w_p1_gnt ? p1_we    : p0_we;
  assign w_sel_addr  = w_p1_gnt ? p1_addr  : p0_addr;
  assign w_sel_wdata = w_p1_gnt ? p1_wdata : p0_wdata;
  assign w_in_range  = ({1'b0, w_sel_addr} < c_depth);

  assign w_mem_we    = w_init_adv | (w_gnt & w_sel_we & w_in_range);
  assign w_mem_addr  = w_init_adv ? r_init_cnt : w_sel_addr;
  assign w_mem_wdata = w_init_adv ? '0 : w_sel_wdata;
  assign w_rd_data   = w_in_range ? r_mem[w_sel_addr] : '0;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
      r_addr_err  <= 1'b0;
    end else begin
      r_p0_rvalid <= w_p0_gnt & ~p0_we;
      r_p1_rvalid <= w_p1_gnt & ~p1_we;
      r_addr_err  <= w_gnt & ~w_in_range;
      if (w_p0_gnt && !p0_we) begin
        r_p0_rdata <= w_rd_data;
      end
      if (w_p1_gnt && !p1_we) begin
        r_p1_rdata <= w_rd_data;
      end
    end
  end

  assign ready     = (r_state == ST_RUN);
  assign p0_gnt    = w_p0_gnt;
  assign p1_gnt    = w_p1_gnt;
  assign p0_rvalid = r_p0_rvalid;
  assign p1_rvalid = r_p1_rvalid;
  assign p0_rdata  = r_p0_rdata;
  assign p1_rdata  = r_p1_rdata;
  assign addr_err  = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_matrix_row_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_row_ram
// Brief    : Randomized self-checking bench for matrix_row_ram (DEPTH=20 build)
//            against an array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_row_ram;

  localparam int DATA_W = 1024;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 20;

  logic              clk;
  logic              reset;
  logic              ena;
  logic              ready;
  logic              p0_req, p0_we, p0_gnt, p0_rvalid;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata, p0_rdata;
  logic              p1_req, p1_we, p1_gnt, p1_rvalid;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata, p1_rdata;
  logic              addr_err;

  matrix_row_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ena(ena), .ready(ready),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  logic [DATA_W-1:0] m_mem [DEPTH];
  int                init_left;
  bit                rr_next;
  bit                e_rv0, e_rv1, e_err;
  logic [DATA_W-1:0] e_rd0, e_rd1;
  bit                g0, g1;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (low 128 bits)", tag, obs[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic model_reset();
    init_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    rr_next = 1'b0;
    e_rv0 = 1'b0; e_rv1 = 1'b0; e_err = 1'b0;
    e_rd0 = '0;   e_rd1 = '0;
  endtask

  // One clock: check DUT at negedge against model, then advance the model.
  task automatic step();
    bit                rdy;
    bit                we;
    int                a;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd;
    @(negedge clk);
    rdy = (init_left == 0);
    g0 = 1'b0;
    g1 = 1'b0;
    if (rdy && ena) begin
      if (p0_req && p1_req) begin
`ifdef MATRIX_ROW_RAM_RR_ARB_EN
        if (rr_next) g1 = 1'b1; else g0 = 1'b1;
`else
        g0 = 1'b1;
`endif
      end else begin
        g0 = p0_req;
        g1 = p1_req;
      end
    end
    chk("ready",     DATA_W'(ready),     DATA_W'(rdy));
    chk("p0_gnt",    DATA_W'(p0_gnt),    DATA_W'(g0));
    chk("p1_gnt",    DATA_W'(p1_gnt),    DATA_W'(g1));
    chk("p0_rvalid", DATA_W'(p0_rvalid), DATA_W'(e_rv0));
    chk("p1_rvalid", DATA_W'(p1_rvalid), DATA_W'(e_rv1));
    chk("addr_err",  DATA_W'(addr_err),  DATA_W'(e_err));
    chk("p0_rdata",  p0_rdata, e_rd0);
    chk("p1_rdata",  p1_rdata, e_rd1);
    if (reset) begin
      model_reset();
    end else begin
      e_rv0 = 1'b0; e_rv1 = 1'b0; e_err = 1'b0;
      if (g0 || g1) begin
        we = g1 ? p1_we : p0_we;
        a  = g1 ? int'(p1_addr) : int'(p0_addr);
        wd = g1 ? p1_wdata : p0_wdata;
        if (a >= DEPTH) e_err = 1'b1;
        if (we) begin
          if (a < DEPTH) m_mem[a] = wd;
        end else begin
          rd = (a < DEPTH) ? m_mem[a] : '0;
          if (g1) begin e_rv1 = 1'b1; e_rd1 = rd; end
          else    begin e_rv0 = 1'b1; e_rd0 = rd; end
        end
        rr_next = g0;
      end
      if (!rdy && ena) init_left--;
    end
    @(posedge clk);
    #1;
  endtask

  // Present one request on a port, hold it until granted, then drop it.
  task automatic access(input bit port, input bit we, input int addr,
                        input logic [DATA_W-1:0] wd);
    bit done;
    done = 1'b0;
    if (port) begin
      p1_req = 1'b1; p1_we = we; p1_addr = ADDR_W'(addr); p1_wdata = wd;
    end else begin
      p0_req = 1'b1; p0_we = we; p0_addr = ADDR_W'(addr); p0_wdata = wd;
    end
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      done = port ? g1 : g0;
    end
    chk("access_grant_timeout", DATA_W'(done), DATA_W'(1'b1));
    if (port) p1_req = 1'b0; else p0_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] pat;
    reset = 1'b1; ena = 1'b0;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    model_reset();
    @(posedge clk);
    #1;
    step();
    reset = 1'b0;
    ena   = 1'b1;

    // Init sweep, then every row reads back zero
    repeat (DEPTH) step();
    for (int a = 0; a < DEPTH; a++) access(1'b0, 1'b0, a, '0);
    step();

    // Write then immediate read on the same port
    pat = {(DATA_W / 8){8'hA5}};
    access(1'b0, 1'b1, 7, pat);
    access(1'b0, 1'b0, 7, '0);
    step();

    // Contention: both ports hold reads for 6 cycles
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = ADDR_W'(7);
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = ADDR_W'(1);
    repeat (6) step();
    p0_req = 1'b0; p1_req = 1'b0;
    step();

    // Out-of-range write then read on port 1
    access(1'b1, 1'b1, 25, rand_word());
    step();
    access(1'b1, 1'b0, 25, '0);
    step();

    // ena gating with a read in flight as ena falls
    access(1'b0, 1'b0, 7, '0);
    ena = 1'b0;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = ADDR_W'(3);
    repeat (3) step();
    ena = 1'b1;
    step();
    p0_req = 1'b0;
    step();

    // Reset while a read is in flight; both ports wait through re-init
    pat = '1;
    access(1'b0, 1'b1, 3, pat);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = ADDR_W'(3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = ADDR_W'(5);
    for (int i = 0; i < 200 && (p0_req || p1_req); i++) begin
      step();
      if (g0) p0_req = 1'b0;
      if (g1) p1_req = 1'b0;
    end
    chk("reinit_grant_timeout", DATA_W'(p0_req | p1_req), '0);
    p0_req = 1'b0; p1_req = 1'b0;
    step();

    // Randomized traffic on both ports
    for (int c = 0; c < 600; c++) begin
      if (!p0_req && $urandom_range(0, 2) != 0) begin
        p0_req = 1'b1; p0_we = 1'($urandom_range(0, 1));
        p0_addr = ADDR_W'($urandom_range(0, 23)); p0_wdata = rand_word();
      end
      if (!p1_req && $urandom_range(0, 2) != 0) begin
        p1_req = 1'b1; p1_we = 1'($urandom_range(0, 1));
        p1_addr = ADDR_W'($urandom_range(0, 23)); p1_wdata = rand_word();
      end
      ena = ($urandom_range(0, 7) != 0);
      step();
      if (g0) p0_req = 1'b0;
      if (g1) p1_req = 1'b0;
    end
    p0_req = 1'b0; p1_req = 1'b0; ena = 1'b1;
    step();
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
